// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding (also used by the TAP FSM),
// instruction opcodes, IR capture pattern and the DR selection type.
package jtag_pkg;

    localparam logic [4:0] TAP_TEST_LOGIC_RESET = 5'h00;
    localparam logic [4:0] TAP_RUN_TEST_IDLE    = 5'h01;
    localparam logic [4:0] TAP_SELECT_DR        = 5'h02;
    localparam logic [4:0] TAP_CAPTURE_DR       = 5'h03;
    localparam logic [4:0] TAP_SHIFT_DR         = 5'h04;
    localparam logic [4:0] TAP_EXIT1_DR         = 5'h05;
    localparam logic [4:0] TAP_PAUSE_DR         = 5'h06;
    localparam logic [4:0] TAP_EXIT2_DR         = 5'h07;
    localparam logic [4:0] TAP_UPDATE_DR        = 5'h08;
    localparam logic [4:0] TAP_SELECT_IR        = 5'h09;
    localparam logic [4:0] TAP_CAPTURE_IR       = 5'h0A;
    localparam logic [4:0] TAP_SHIFT_IR         = 5'h0B;
    localparam logic [4:0] TAP_EXIT1_IR         = 5'h0C;
    localparam logic [4:0] TAP_PAUSE_IR         = 5'h0D;
    localparam logic [4:0] TAP_EXIT2_IR         = 5'h0E;
    localparam logic [4:0] TAP_UPDATE_IR        = 5'h0F;

    localparam logic [3:0] OP_ABORT  = 4'b1000;
    localparam logic [3:0] OP_IDCODE = 4'b1110;
    localparam logic [3:0] OP_BYPASS = 4'b1111;
    localparam logic [3:0] OP_USER   = 4'b1010;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    function automatic logic is_ir_state(input logic [4:0] st);
        return (st >= TAP_SELECT_IR) && (st <= TAP_UPDATE_IR);
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic JTAG scan register: parallel capture, LSB-first right shift with
// serial input at the MSB, otherwise hold.
module jtag_shift_reg
    import jtag_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             tck,
    input  logic             trst_n,
    input  logic             capture,
    input  logic             shift,
    input  logic [WIDTH-1:0] cap_val,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign q_shifted = si;
        end else begin : g_multi
            assign q_shifted = {si, q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            q <= '0;
        end else if (capture) begin
            q <= cap_val;
        end else if (shift) begin
            q <= q_shifted;
        end
    end

endmodule

// File: rtl/jtag_scan_ctrl.sv
// Scan-chain controller following the TAP state: IR/DR capture-shift-update,
// TDO drive and instruction side-effect pulses. Optional user DR: JTAG_USER_DR_EN.
module jtag_scan_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VALUE  = 32'h000FAF01,
    parameter int          USER_DR_WIDTH = 8
) (
    input  logic                     tck,
    input  logic                     trst_n,
    input  logic                     tdi,
    input  logic [4:0]               tap_state,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [IR_WIDTH-1:0]      ir_value,
    output logic                     abort_pulse,
    input  logic [USER_DR_WIDTH-1:0] user_status,
    output logic [USER_DR_WIDTH-1:0] user_data,
    output logic                     user_update
);

    logic st_tlr, st_capture_ir, st_shift_ir, st_update_ir;
    logic st_capture_dr, st_shift_dr, st_update_dr;
    logic in_ir_states;
    dr_sel_e dr_sel;

    logic [IR_WIDTH-1:0] ir_q;
    logic [31:0]         idcode_q;
    logic                bypass_q;
    logic                dr_lsb;

    // Unknown encodings match none of these and therefore act as idle.
    always_comb begin
        st_tlr        = (tap_state == TAP_TEST_LOGIC_RESET);
        st_capture_ir = (tap_state == TAP_CAPTURE_IR);
        st_shift_ir   = (tap_state == TAP_SHIFT_IR);
        st_update_ir  = (tap_state == TAP_UPDATE_IR);
        st_capture_dr = (tap_state == TAP_CAPTURE_DR);
        st_shift_dr   = (tap_state == TAP_SHIFT_DR);
        st_update_dr  = (tap_state == TAP_UPDATE_DR);
        in_ir_states  = is_ir_state(tap_state);
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_value == IR_WIDTH'(OP_IDCODE)) begin
            dr_sel = DR_IDCODE;
        end
`ifdef JTAG_USER_DR_EN
        else if (ir_value == IR_WIDTH'(OP_USER)) begin
            dr_sel = DR_USER;
        end
`endif
    end

    jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir (
        .tck     (tck),
        .trst_n  (trst_n),
        .capture (st_capture_ir),
        .shift   (st_shift_ir),
        .cap_val (IR_WIDTH'(IR_CAPTURE)),
        .si      (tdi),
        .q       (ir_q)
    );

    jtag_shift_reg #(.WIDTH(32)) u_idcode (
        .tck     (tck),
        .trst_n  (trst_n),
        .capture (st_capture_dr && (dr_sel == DR_IDCODE)),
        .shift   (st_shift_dr && (dr_sel == DR_IDCODE)),
        .cap_val (IDCODE_VALUE),
        .si      (tdi),
        .q       (idcode_q)
    );

    jtag_shift_reg #(.WIDTH(1)) u_bypass (
        .tck     (tck),
        .trst_n  (trst_n),
        .capture (st_capture_dr && (dr_sel == DR_BYPASS)),
        .shift   (st_shift_dr && (dr_sel == DR_BYPASS)),
        .cap_val (1'b0),
        .si      (tdi),
        .q       (bypass_q)
    );

    // Only the serial end of the IDCODE register is observed.
    logic unused_bits;

`ifdef JTAG_USER_DR_EN
    logic [USER_DR_WIDTH-1:0] user_q;

    jtag_shift_reg #(.WIDTH(USER_DR_WIDTH)) u_user (
        .tck     (tck),
        .trst_n  (trst_n),
        .capture (st_capture_dr && (dr_sel == DR_USER)),
        .shift   (st_shift_dr && (dr_sel == DR_USER)),
        .cap_val (user_status),
        .si      (tdi),
        .q       (user_q)
    );

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            user_data   <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= st_update_dr && (dr_sel == DR_USER);
            if (st_update_dr && (dr_sel == DR_USER)) begin
                user_data <= user_q;
            end
        end
    end

    assign unused_bits = ^idcode_q[31:1];
`else
    assign user_data   = '0;
    assign user_update = 1'b0;
    assign unused_bits = ^{idcode_q[31:1], user_status};
`endif

    always_comb begin
        dr_lsb = bypass_q;
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_q[0];
`ifdef JTAG_USER_DR_EN
            DR_USER:   dr_lsb = user_q[0];
`endif
            default:   dr_lsb = bypass_q;
        endcase
    end

    // Gated by trst_n so both outputs drop the moment reset asserts.
    assign tdo    = trst_n & (in_ir_states ? ir_q[0] : dr_lsb);
    assign tdo_en = trst_n & (st_shift_ir | st_shift_dr);

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_value    <= IR_WIDTH'(OP_IDCODE);
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= st_update_dr && (ir_value == IR_WIDTH'(OP_ABORT));
            if (st_tlr) begin
                ir_value <= IR_WIDTH'(OP_IDCODE);
            end else if (st_update_ir) begin
                ir_value <= ir_q;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Directed bench for jtag_scan_ctrl; user-DR checks follow JTAG_USER_DR_EN.
module tb_jtag_scan_ctrl;
    import jtag_pkg::*;

    logic       tck = 1'b0;
    logic       trst_n;
    logic       tdi;
    logic [4:0] tap_state;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir_value;
    logic       abort_pulse;
    logic [7:0] user_status;
    logic [7:0] user_data;
    logic       user_update;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 tck = ~tck;

    jtag_scan_ctrl #(
        .IR_WIDTH      (4),
        .IDCODE_VALUE  (32'h000FAF01),
        .USER_DR_WIDTH (8)
    ) dut (
        .tck         (tck),
        .trst_n      (trst_n),
        .tdi         (tdi),
        .tap_state   (tap_state),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .ir_value    (ir_value),
        .abort_pulse (abort_pulse),
        .user_status (user_status),
        .user_data   (user_data),
        .user_update (user_update)
    );

    // Drive one TAP cycle; returns before the consuming posedge.
    task automatic step(input logic [4:0] st, input logic d);
        @(negedge tck);
        tap_state = st;
        tdi       = d;
        #1;
    endtask

    task automatic ir_scan(input logic [3:0] op, output logic [3:0] seen);
        seen = '0;
        step(TAP_SELECT_DR, 1'b0);
        step(TAP_SELECT_IR, 1'b0);
        step(TAP_CAPTURE_IR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(TAP_SHIFT_IR, op[i]);
            seen[i] = tdo;
        end
        step(TAP_EXIT1_IR, 1'b0);
        step(TAP_UPDATE_IR, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);
    endtask

    // Ends in UpdateDr, before that edge has been taken.
    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        step(TAP_SELECT_DR, 1'b0);
        step(TAP_CAPTURE_DR, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(TAP_SHIFT_DR, din[i]);
            dout[i] = tdo;
            n_cmp++;
            if (tdo_en !== 1'b1) begin
                n_bad++;
                $display("FAIL dr_tdo_en bit %0d: got %b want 1", i, tdo_en);
            end
        end
        step(TAP_EXIT1_DR, 1'b0);
        step(TAP_UPDATE_DR, 1'b0);
    endtask

    task automatic test_reset();
        trst_n      = 1'b0;
        tdi         = 1'b0;
        tap_state   = TAP_TEST_LOGIC_RESET;
        user_status = 8'h00;
        repeat (2) @(posedge tck);
        #1;
        n_cmp++; if (ir_value !== 4'b1110) begin n_bad++; $display("FAIL reset_ir_value: got %b want 1110", ir_value); end
        n_cmp++; if (tdo !== 1'b0) begin n_bad++; $display("FAIL reset_tdo: got %b want 0", tdo); end
        n_cmp++; if (tdo_en !== 1'b0) begin n_bad++; $display("FAIL reset_tdo_en: got %b want 0", tdo_en); end
        n_cmp++; if (abort_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_abort: got %b want 0", abort_pulse); end
        n_cmp++; if (user_update !== 1'b0) begin n_bad++; $display("FAIL reset_user_update: got %b want 0", user_update); end
        n_cmp++; if (user_data !== 8'h00) begin n_bad++; $display("FAIL reset_user_data: got %h want 00", user_data); end
        @(negedge tck);
        trst_n = 1'b1;
    endtask

    task automatic test_idcode();
        logic [31:0] dout;
        step(TAP_TEST_LOGIC_RESET, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);
        dr_scan(32, 32'h0, dout);
        n_cmp++; if (dout !== 32'h000FAF01) begin n_bad++; $display("FAIL idcode_tdo: got %h want 000faf01", dout); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
        n_cmp++; if (tdo_en !== 1'b0) begin n_bad++; $display("FAIL idle_tdo_en: got %b want 0", tdo_en); end
    endtask

    task automatic test_bypass();
        logic [3:0]  seen;
        logic [31:0] dout;
        ir_scan(4'b1111, seen);
        n_cmp++; if (seen !== 4'b0001) begin n_bad++; $display("FAIL ir_capture_tdo: got %b want 0001", seen); end
        n_cmp++; if (ir_value !== 4'b1111) begin n_bad++; $display("FAIL bypass_ir_value: got %b want 1111", ir_value); end
        dr_scan(3, 32'b101, dout);
        n_cmp++; if (dout[2:0] !== 3'b010) begin n_bad++; $display("FAIL bypass_tdo: got %b want 010", dout[2:0]); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
    endtask

    task automatic test_pause_resume();
        logic [11:0] seen;
        seen = '0;
        step(TAP_TEST_LOGIC_RESET, 1'b0);
        step(TAP_SELECT_DR, 1'b0);
        step(TAP_CAPTURE_DR, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(TAP_SHIFT_DR, 1'b0);
            seen[i] = tdo;
        end
        step(TAP_EXIT1_DR, 1'b0);
        step(TAP_PAUSE_DR, 1'b1);
        step(5'h1F, 1'b1);
        n_cmp++; if (tdo_en !== 1'b0) begin n_bad++; $display("FAIL unknown_state_tdo_en: got %b want 0", tdo_en); end
        step(TAP_PAUSE_DR, 1'b1);
        step(TAP_EXIT2_DR, 1'b1);
        n_cmp++; if (ir_value !== 4'b1110) begin n_bad++; $display("FAIL pause_ir_value: got %b want 1110", ir_value); end
        for (int i = 8; i < 12; i++) begin
            step(TAP_SHIFT_DR, 1'b0);
            seen[i] = tdo;
        end
        n_cmp++; if (seen !== 12'hF01) begin n_bad++; $display("FAIL pause_resume_tdo: got %h want f01", seen); end
        step(TAP_EXIT1_DR, 1'b0);
        step(TAP_UPDATE_DR, 1'b0);
        step(TAP_RUN_TEST_IDLE, 1'b0);
    endtask

    task automatic test_abort();
        logic [3:0]  seen;
        logic [31:0] dout;
        ir_scan(4'b1000, seen);
        n_cmp++; if (ir_value !== 4'b1000) begin n_bad++; $display("FAIL abort_ir_value: got %b want 1000", ir_value); end
        dr_scan(1, 32'h0, dout);
        n_cmp++; if (abort_pulse !== 1'b0) begin n_bad++; $display("FAIL abort_early: got %b want 0", abort_pulse); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
        n_cmp++; if (abort_pulse !== 1'b1) begin n_bad++; $display("FAIL abort_pulse: got %b want 1", abort_pulse); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
        n_cmp++; if (abort_pulse !== 1'b0) begin n_bad++; $display("FAIL abort_width: got %b want 0", abort_pulse); end
        n_cmp++; if (ir_value !== 4'b1000) begin n_bad++; $display("FAIL abort_ir_kept: got %b want 1000", ir_value); end
    endtask

    task automatic test_user();
        logic [3:0]  seen;
        logic [31:0] dout;
        ir_scan(4'b1010, seen);
`ifdef JTAG_USER_DR_EN
        user_status = 8'hA5;
        dr_scan(8, 32'h3C, dout);
        n_cmp++; if (dout[7:0] !== 8'hA5) begin n_bad++; $display("FAIL user_tdo: got %h want a5", dout[7:0]); end
        n_cmp++; if (user_update !== 1'b0) begin n_bad++; $display("FAIL user_update_early: got %b want 0", user_update); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
        n_cmp++; if (user_update !== 1'b1) begin n_bad++; $display("FAIL user_update: got %b want 1", user_update); end
        n_cmp++; if (user_data !== 8'h3C) begin n_bad++; $display("FAIL user_data: got %h want 3c", user_data); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
        n_cmp++; if (user_update !== 1'b0) begin n_bad++; $display("FAIL user_update_width: got %b want 0", user_update); end
`else
        user_status = 8'hA5;
        dr_scan(3, 32'b101, dout);
        n_cmp++; if (dout[2:0] !== 3'b010) begin n_bad++; $display("FAIL user_as_bypass_tdo: got %b want 010", dout[2:0]); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
        n_cmp++; if (user_update !== 1'b0) begin n_bad++; $display("FAIL user_update_off: got %b want 0", user_update); end
        n_cmp++; if (user_data !== 8'h00) begin n_bad++; $display("FAIL user_data_off: got %h want 00", user_data); end
`endif
    endtask

    task automatic test_illegal_code();
        logic [3:0]  seen;
        logic [31:0] dout;
        ir_scan(4'b0011, seen);
        n_cmp++; if (ir_value !== 4'b0011) begin n_bad++; $display("FAIL illegal_ir_value: got %b want 0011", ir_value); end
        dr_scan(3, 32'b110, dout);
        n_cmp++; if (dout[2:0] !== 3'b100) begin n_bad++; $display("FAIL illegal_bypass_tdo: got %b want 100", dout[2:0]); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
    endtask

    task automatic test_tlr_mid_scan();
        logic [3:0] seen;
        ir_scan(4'b1111, seen);
        step(TAP_SELECT_DR, 1'b0);
        step(TAP_CAPTURE_DR, 1'b0);
        step(TAP_SHIFT_DR, 1'b1);
        step(TAP_TEST_LOGIC_RESET, 1'b0);
        n_cmp++; if (tdo_en !== 1'b0) begin n_bad++; $display("FAIL tlr_tdo_en: got %b want 0", tdo_en); end
        step(TAP_RUN_TEST_IDLE, 1'b0);
        n_cmp++; if (ir_value !== 4'b1110) begin n_bad++; $display("FAIL tlr_ir_value: got %b want 1110", ir_value); end
    endtask

    task automatic test_async_reset_mid_shift();
        logic [3:0]  seen;
        logic [31:0] dout;
        ir_scan(4'b1000, seen);
        dr_scan(1, 32'h0, dout);
        step(TAP_SHIFT_DR, 1'b1);
        n_cmp++; if (abort_pulse !== 1'b1) begin n_bad++; $display("FAIL pre_reset_abort: got %b want 1", abort_pulse); end
        n_cmp++; if (tdo_en !== 1'b1) begin n_bad++; $display("FAIL pre_reset_tdo_en: got %b want 1", tdo_en); end
        #2;
        trst_n = 1'b0;
        #1;
        n_cmp++; if (ir_value !== 4'b1110) begin n_bad++; $display("FAIL async_ir_value: got %b want 1110", ir_value); end
        n_cmp++; if (tdo_en !== 1'b0) begin n_bad++; $display("FAIL async_tdo_en: got %b want 0", tdo_en); end
        n_cmp++; if (tdo !== 1'b0) begin n_bad++; $display("FAIL async_tdo: got %b want 0", tdo); end
        n_cmp++; if (abort_pulse !== 1'b0) begin n_bad++; $display("FAIL async_abort: got %b want 0", abort_pulse); end
        n_cmp++; if (user_update !== 1'b0) begin n_bad++; $display("FAIL async_user_update: got %b want 0", user_update); end
        @(negedge tck);
        trst_n = 1'b1;
        step(TAP_TEST_LOGIC_RESET, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bypass();
        test_pause_resume();
        test_abort();
        test_user();
        test_illegal_code();
        test_tlr_mid_scan();
        test_async_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
